// File: rtl/refresh_pkg.sv
// Shared definitions for the DRAM refresh scheduler: FSM encoding and
// default timing parameters.
package refresh_pkg;

  localparam int DEF_TREFI         = 6400000;
  localparam int DEF_TRFC          = 128;
  localparam int DEF_MAX_POSTPONE  = 8;
  localparam int DEF_URGENT_THRESH = 6;

  typedef enum logic [1:0] {
    ST_DIS     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PEND    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/refresh_scheduler_interval_timer.sv
// Free-running interval counter: counts 0..PERIOD-1 while enabled and
// pulses tick on the cycle that wraps back to 0.
module interval_timer
  import refresh_pkg::*;
#(
  parameter int PERIOD = DEF_TREFI
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: accumulates refresh obligations every TREFI cycles,
// requests REF from the controller, and enforces TRFC recovery after each ack.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int TREFI         = DEF_TREFI,
  parameter int TRFC          = DEF_TRFC,
  parameter int MAX_POSTPONE  = DEF_MAX_POSTPONE,
  parameter int URGENT_THRESH = DEF_URGENT_THRESH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                ref_ack,
  output logic                                ref_req,
  output logic                                ref_urgent,
  output logic [$clog2(MAX_POSTPONE+1)-1:0]   pending,
  output logic                                overrun,
  output logic                                ack_err
);

  localparam int PW = $clog2(MAX_POSTPONE + 1);
  localparam int RW = (TRFC > 1) ? $clog2(TRFC) : 1;
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_POSTPONE);
  localparam logic [PW-1:0] PEND_URG = PW'(URGENT_THRESH);
  localparam logic [RW-1:0] REC_LOAD = RW'(TRFC - 1);

  state_t        state, state_d;
  logic [PW-1:0] pending_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic          tick;
  logic          ack_ok;
  logic          overrun_set;
  logic          in_pend;

  // The interval only runs once the FSM has left DIS, so a fresh enable
  // always starts a full TREFI interval from zero.
  interval_timer #(.PERIOD(TREFI)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (enable && (state != ST_DIS)),
    .tick (tick)
  );

  assign in_pend = enable && (state == ST_PEND);
  assign ack_ok  = ref_ack && in_pend;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    pending_d   = pending;
    rcnt_d      = rcnt;
    overrun_set = 1'b0;
    if (!enable) begin
      state_d   = ST_DIS;
      pending_d = '0;
      rcnt_d    = '0;
    end else begin
      case (state)
        ST_DIS: state_d = ST_IDLE;
        ST_IDLE: begin
          if (tick) begin
            pending_d = PW'(1);
            state_d   = ST_PEND;
          end
        end
        ST_PEND: begin
          if (ack_ok) begin
            // A tick landing on the ack cycle cancels the decrement.
            if (!tick) pending_d = pending - PW'(1);
            rcnt_d  = REC_LOAD;
            state_d = ST_RECOVER;
          end else if (tick) begin
            if (pending == PEND_MAX) overrun_set = 1'b1;
            else                     pending_d   = pending + PW'(1);
          end
        end
        ST_RECOVER: begin
          if (tick) begin
            if (pending == PEND_MAX) overrun_set = 1'b1;
            else                     pending_d   = pending + PW'(1);
          end
          if (rcnt == '0) state_d = (pending_d != '0) ? ST_PEND : ST_IDLE;
          else            rcnt_d  = rcnt - RW'(1);
        end
        default: state_d = ST_DIS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_DIS;
      pending    <= '0;
      rcnt       <= '0;
      ref_req    <= 1'b0;
      ref_urgent <= 1'b0;
      overrun    <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      rcnt       <= rcnt_d;
      ref_req    <= in_pend;
      ref_urgent <= in_pend && (pending >= PEND_URG);
      if (overrun_set)          overrun <= 1'b1;
      if (ref_ack && !ack_ok)   ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench for refresh_scheduler against a cycle-count model of
// pending obligations, recovery windows and sticky error flags.
module tb_refresh_scheduler;

  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 8;
  localparam int URG   = 6;
  localparam int PW    = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          ref_ack;
  logic          ref_req;
  logic          ref_urgent;
  logic [PW-1:0] pending;
  logic          overrun;
  logic          ack_err;

  int checks = 0;
  int errors = 0;

  // Reference model: obligations since enable, recovery cycles remaining.
  bit m_active;
  int m_age;
  int m_pending;
  int m_rec;
  bit m_req, m_urg, m_ovr, m_err;

  refresh_scheduler #(
    .TREFI(TREFI), .TRFC(TRFC), .MAX_POSTPONE(MAXP), .URGENT_THRESH(URG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ref_ack   (ref_ack),
    .ref_req   (ref_req),
    .ref_urgent(ref_urgent),
    .pending   (pending),
    .overrun   (overrun),
    .ack_err   (ack_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_in_pend();
    return m_active && (m_rec == 0) && (m_pending > 0);
  endfunction

  function automatic logic [PW+3:0] m_vec();
    return {m_req, m_urg, PW'(m_pending), m_ovr, m_err};
  endfunction

  function automatic logic [PW+3:0] dut_vec();
    return {ref_req, ref_urgent, pending, overrun, ack_err};
  endfunction

  function automatic void m_clear(input bit keep_sticky);
    m_active = 0; m_age = 0; m_pending = 0; m_rec = 0;
    m_req = 0; m_urg = 0;
    if (!keep_sticky) begin m_ovr = 0; m_err = 0; end
  endfunction

  // Advance the model by one clock edge with the inputs that edge sampled.
  function automatic void m_edge(input bit en, input bit ack);
    bit tick, ok;
    tick = m_active && en && ((m_age % TREFI) == TREFI - 1);
    ok   = ack && en && m_in_pend();
    if (ack && !ok) m_err = 1;
    m_req = en && m_in_pend();
    m_urg = m_req && (m_pending >= URG);
    if (!en) begin
      m_clear(1);
    end else if (!m_active) begin
      m_active = 1;
      m_age    = 0;
    end else begin
      m_age++;
      if (m_rec > 0) m_rec--;
      if (ok) begin
        m_rec = TRFC;
        if (!tick) m_pending--;
      end else if (tick) begin
        if (m_pending == MAXP) m_ovr = 1;
        else                   m_pending++;
      end
    end
  endfunction

  function automatic bit m_tick_next(input bit en);
    return m_active && en && ((m_age % TREFI) == TREFI - 1);
  endfunction

  task automatic step(input bit en, input bit ack);
    enable  = en;
    ref_ack = ack;
    @(posedge clk);
    m_edge(en, ack);
    #1;
    ref_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b0;
    ref_ack = 1'b0;
    m_clear(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    do_reset();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", dut_vec(), '0);
    end
    step(1'b0, 1'b0);
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_disabled got %b expected %b", dut_vec(), '0);
    end
  endtask

  task automatic test_first_request();
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL first_req_model edge %0d got %b expected %b", k, dut_vec(), m_vec());
      end
      if (k == 16) begin
        checks++;
        if (pending !== PW'(1) || ref_req !== 1'b0) begin
          errors++;
          $display("FAIL first_req_edge16 got pending=%0d req=%b expected pending=1 req=0", pending, ref_req);
        end
      end
      if (k == 17) begin
        checks++;
        if (ref_req !== 1'b1) begin
          errors++;
          $display("FAIL first_req_edge17 got req=%b expected 1", ref_req);
        end
      end
    end
  endtask

  // Continues from test_first_request: ack two cycles after ref_req rises.
  task automatic test_ack_recovery();
    int low_cycles;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("FAIL ack_pending got %0d expected 0", pending);
    end
    low_cycles = 0;
    for (int k = 20; k <= 33; k++) begin
      step(1'b1, 1'b0);
      if (k <= 32 && ref_req === 1'b0) low_cycles++;
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL ack_recovery_model edge %0d got %b expected %b", k, dut_vec(), m_vec());
      end
    end
    checks++;
    if (low_cycles != 13 || ref_req !== 1'b1 || pending !== PW'(1)) begin
      errors++;
      $display("FAIL ack_recovery_low got low=%0d req=%b pending=%0d expected low=13 req=1 pending=1",
               low_cycles, ref_req, pending);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k <= 145; k++) begin
      step(1'b1, 1'b0);
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL saturation_model edge %0d got %b expected %b", k, dut_vec(), m_vec());
      end
      if (k == 97) begin
        checks++;
        if (pending !== PW'(6) || ref_urgent !== 1'b1) begin
          errors++;
          $display("FAIL urgent_at_6 got pending=%0d urg=%b expected 6 1", pending, ref_urgent);
        end
      end
      if (k == 128) begin
        checks++;
        if (pending !== PW'(8) || overrun !== 1'b0) begin
          errors++;
          $display("FAIL pending_at_8 got pending=%0d ovr=%b expected 8 0", pending, overrun);
        end
      end
      if (k == 144) begin
        checks++;
        if (pending !== PW'(8) || overrun !== 1'b1) begin
          errors++;
          $display("FAIL overrun_9th got pending=%0d ovr=%b expected 8 1", pending, overrun);
        end
      end
    end
  endtask

  task automatic test_tick_ack_collision();
    int low_cycles;
    do_reset();
    for (int k = 0; k <= 63; k++) step(1'b1, 1'b0);
    checks++;
    if (pending !== PW'(3) || !m_tick_next(1'b1)) begin
      errors++;
      $display("FAIL collision_setup got pending=%0d expected 3 with tick due", pending);
    end
    step(1'b1, 1'b1);
    checks++;
    if (pending !== PW'(3)) begin
      errors++;
      $display("FAIL collision_pending got %0d expected 3", pending);
    end
    low_cycles = 0;
    for (int k = 65; k <= 69; k++) begin
      step(1'b1, 1'b0);
      if (k <= 68 && ref_req === 1'b0) low_cycles++;
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL collision_model edge %0d got %b expected %b", k, dut_vec(), m_vec());
      end
    end
    checks++;
    if (low_cycles != 4 || ref_req !== 1'b1) begin
      errors++;
      $display("FAIL collision_recover got low=%0d req=%b expected low=4 req=1", low_cycles, ref_req);
    end
  endtask

  task automatic test_ack_in_idle();
    do_reset();
    for (int k = 0; k <= 45; k++) begin
      step(1'b1, k == 5);
      checks++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL idle_ack_model edge %0d got %b expected %b", k, dut_vec(), m_vec());
      end
    end
    checks++;
    if (ack_err !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack_sticky got %b expected 1", ack_err);
    end
  endtask

  task automatic test_reset_mid_recover();
    do_reset();
    for (int k = 0; k <= 97; k++) step(1'b1, k == 97);
    step(1'b1, 1'b0);
    checks++;
    if (pending !== PW'(5) || ref_req !== 1'b0) begin
      errors++;
      $display("FAIL recover_setup got pending=%0d req=%b expected 5 0", pending, ref_req);
    end
    #2 rst_n = 1'b0;
    m_clear(0);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset got %b expected 0", dut_vec());
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b expected 0", dut_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_reset();
    for (int k = 0; k <= 147; k++) step(1'b1, (k == 3) || (k == 146));
    checks++;
    if (pending !== PW'(7) || overrun !== 1'b1 || ack_err !== 1'b1) begin
      errors++;
      $display("FAIL disable_setup got pending=%0d ovr=%b err=%b expected 7 1 1", pending, overrun, ack_err);
    end
    step(1'b0, 1'b0);
    checks++;
    if (dut_vec() !== m_vec() || pending !== '0 || overrun !== 1'b1 || ack_err !== 1'b1) begin
      errors++;
      $display("FAIL disable_retain got %b expected %b", dut_vec(), m_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int k = 0; k < 500; k++) begin
        step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 25);
        checks++;
        if (dut_vec() !== m_vec()) begin
          errors++;
          if (bad < 10)
            $display("FAIL random blk %0d cyc %0d got %b expected %b", blk, k, dut_vec(), m_vec());
          bad++;
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    ref_ack = 1'b0;
    test_reset();
    test_first_request();
    test_ack_recovery();
    test_saturation();
    test_tick_ack_collision();
    test_ack_in_idle();
    test_reset_mid_recover();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
